dmem_mc: RTL and testbench

//  Multi-cycle data memory: parametrised successor of the single-cycle dmem for the multi-stage processor.

---
 rtl/dmem_mc_pkg.sv | 29 ++
 rtl/dmem_mc.sv | 165 ++++++++++++++++
 tb/tb_dmem_mc.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_mc_pkg.sv
// Shared encodings for the multi-cycle data memory: access-size codes (also used by
// the MEM-stage control), controller states and the alignment helper.
package dmem_mc_pkg;

  typedef enum logic [1:0] {
    DSIZE_WORD = 2'b00,
    DSIZE_HALF = 2'b01,
    DSIZE_BYTE = 2'b10,
    DSIZE_RSVD = 2'b11
  } dsize_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int CNT_W = 4;

  // Reserved size code behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      DSIZE_BYTE: return 1'b0;
      DSIZE_HALF: return lsb[0];
      default:    return lsb != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_mc.sv
// Multi-cycle big-endian byte-addressed data memory with req/ready/done handshake.
// Define DMEM_MISALIGN_CHK_EN to flag (and suppress) misaligned half/word accesses via err.
module dmem_mc
  import dmem_mc_pkg::*;
#(
  parameter int SIZE    = 16384,
  parameter int LATENCY = 2,
  parameter int AW      = 14
) (
  input  logic        clk,
  input  logic        memRst,
  input  logic        req,
  input  logic        writeEnable,
  input  logic [1:0]  dsize,
  input  logic [31:0] addr,
  input  logic [31:0] wData,
  output logic        ready,
  output logic        done,
  output logic [31:0] rData,
  output logic        err
);

  // state  | meaning
  // IDLE   | ready=1, waiting for req
  // BUSY   | access in flight, counting down remaining latency
  // DONE   | done pulse, access already performed on the entering edge

  logic [7:0] mem [0:SIZE-1];

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [1:0]       dsize_q;
  logic [AW-1:0]    idx_q;
  logic [31:0]      wdata_q;
  logic             err_q;

  logic             op_we;
  logic [1:0]       op_dsize;
  logic [AW-1:0]    op_idx;
  logic [31:0]      op_wdata;
  logic             access;
  logic             bad;
  logic [AW-1:0]    b_idx [4];
  logic [7:0]       b_dat [4];
  logic [3:0]       wr_en;
  logic [31:0]      load_val;
  logic             addr_unused;

  assign addr_unused = ^addr[31:AW];
  assign err         = err_q;

  always_comb begin
    op_we    = we_q;
    op_dsize = dsize_q;
    op_idx   = idx_q;
    op_wdata = wdata_q;
    // With single-cycle latency the access happens on the accepting edge itself.
    if (state == ST_IDLE) begin
      op_we    = writeEnable;
      op_dsize = dsize;
      op_idx   = addr[AW-1:0];
      op_wdata = wData;
    end

    access = 1'b0;
    if (!memRst) begin
      if (state == ST_IDLE)      access = req && (LATENCY == 1);
      else if (state == ST_BUSY) access = (cnt == 4'd1);
    end

`ifdef DMEM_MISALIGN_CHK_EN
    bad = is_misaligned(op_dsize, op_idx[1:0]);
`else
    bad = 1'b0;
`endif

    for (int k = 0; k < 4; k++) begin
      b_idx[k] = op_idx + AW'(k);
      b_dat[k] = 8'h00;
    end

    case (op_dsize)
      DSIZE_BYTE: load_val = {24'd0, mem[b_idx[0]]};
      DSIZE_HALF: load_val = {16'd0, mem[b_idx[0]], mem[b_idx[1]]};
      default:    load_val = {mem[b_idx[0]], mem[b_idx[1]], mem[b_idx[2]], mem[b_idx[3]]};
    endcase

    wr_en = 4'b0000;
    if (access && op_we && !bad) begin
      case (op_dsize)
        DSIZE_BYTE: begin
          wr_en    = 4'b0001;
          b_dat[0] = op_wdata[7:0];
        end
        DSIZE_HALF: begin
          wr_en    = 4'b0011;
          b_dat[0] = op_wdata[15:8];
          b_dat[1] = op_wdata[7:0];
        end
        default: begin
          wr_en    = 4'b1111;
          b_dat[0] = op_wdata[31:24];
          b_dat[1] = op_wdata[23:16];
          b_dat[2] = op_wdata[15:8];
          b_dat[3] = op_wdata[7:0];
        end
      endcase
    end
  end

  // Storage is never reset so preloaded contents survive memRst.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en[k]) mem[b_idx[k]] <= b_dat[k];
    end
  end

  always_ff @(posedge clk) begin
    if (memRst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      rData   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      dsize_q <= 2'b00;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            we_q    <= writeEnable;
            dsize_q <= dsize;
            idx_q   <= addr[AW-1:0];
            wdata_q <= wData;
            ready   <= 1'b0;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= (LATENCY == 1) ? ST_DONE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          err_q <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (access) begin
        done  <= 1'b1;
        err_q <= bad;
        if (!op_we && !bad) rData <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_dmem_mc.sv
// Self-checking bench for dmem_mc: directed scenarios plus randomized traffic against
// a byte-array reference model; extra instances cover LATENCY=1 and LATENCY=5 handshakes.
module tb_dmem_mc;

  localparam int SIZE = 16384;
`ifdef DMEM_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        memRst = 1'b1;
  logic        req = 1'b0;
  logic        writeEnable = 1'b0;
  logic [1:0]  dsize = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wData = '0;

  logic        ready, done, err;
  logic [31:0] rData;
  logic        ready1, done1, err_unused1;
  logic [31:0] rdata_unused1;
  logic        ready5, done5, err_unused5;
  logic [31:0] rdata_unused5;

  dmem_mc #(.SIZE(SIZE), .LATENCY(2), .AW(14)) dut (
    .clk(clk), .memRst(memRst), .req(req), .writeEnable(writeEnable), .dsize(dsize),
    .addr(addr), .wData(wData), .ready(ready), .done(done), .rData(rData), .err(err));

  dmem_mc #(.SIZE(SIZE), .LATENCY(1), .AW(14)) dut1 (
    .clk(clk), .memRst(memRst), .req(req), .writeEnable(writeEnable), .dsize(dsize),
    .addr(addr), .wData(wData), .ready(ready1), .done(done1), .rData(rdata_unused1),
    .err(err_unused1));

  dmem_mc #(.SIZE(SIZE), .LATENCY(5), .AW(14)) dut5 (
    .clk(clk), .memRst(memRst), .req(req), .writeEnable(writeEnable), .dsize(dsize),
    .addr(addr), .wData(wData), .ready(ready5), .done(done5), .rData(rdata_unused5),
    .err(err_unused5));

  int total = 0;
  int passed = 0;

  logic [7:0]  model_mem [int];
  logic [31:0] exp_rd = '0;

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b10) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (!CHK) return 1'b0;
    if (sz == 2'b10) return 1'b0;
    if (sz == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  // Reference: big-endian byte sequence at (a+i) mod SIZE.
  function automatic void model_op(input logic we, input logic [1:0] sz, input logic [31:0] a,
                                   input logic [31:0] wd, output bit exp_err);
    int n;
    logic [31:0] v;
    n = nbytes(sz);
    exp_err = misaligned(sz, a);
    if (exp_err) return;
    if (we) begin
      for (int i = 0; i < n; i++)
        model_mem[int'((a + 32'(i)) % SIZE)] = 8'(wd >> (8 * (n - 1 - i)));
    end else begin
      v = '0;
      for (int i = 0; i < n; i++)
        v = (v << 8) | 32'(model_mem[int'((a + 32'(i)) % SIZE)]);
      exp_rd = v;
    end
  endfunction

  // Issue one request from IDLE; returns cycles to done and the outputs seen during done.
  task automatic xfer(input logic we, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, output int lat, output logic [31:0] rd,
                      output logic e, output logic rdy_after);
    writeEnable = we; dsize = sz; addr = a; wData = wd; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = rData;
    e  = err;
    @(negedge clk);
    rdy_after = ready;
  endtask

  task automatic do_reset();
    memRst = 1'b1;
    req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd; logic e, rdy; bit ee;
    do_reset();
    total++; if (ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", ready); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
    total++; if (rData !== 32'h0) $display("FAIL reset_rdata got %h exp 0", rData); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else passed++;
    memRst = 1'b0;
    exp_rd = '0;
    model_op(1'b1, 2'b10, 32'h0, 32'hAB, ee);
    xfer(1'b1, 2'b10, 32'h0, 32'hAB, lat, rd, e, rdy);
    model_op(1'b0, 2'b10, 32'h0, 32'h0, ee);
    xfer(1'b0, 2'b10, 32'h0, 32'h0, lat, rd, e, rdy);
    total++; if (rd !== exp_rd) $display("FAIL preload_load got %h exp %h", rd, exp_rd); else passed++;
    do_reset();
    total++; if (rData !== 32'h0) $display("FAIL reset2_rdata got %h exp 0", rData); else passed++;
    memRst = 1'b0;
    exp_rd = '0;
    total++; if (dut.mem[0] !== model_mem[0]) $display("FAIL mem_survives got %h exp %h", dut.mem[0], model_mem[0]); else passed++;
    model_op(1'b0, 2'b10, 32'h0, 32'h0, ee);
    xfer(1'b0, 2'b10, 32'h0, 32'h0, lat, rd, e, rdy);
    total++; if (rd !== exp_rd) $display("FAIL load_after_reset got %h exp %h", rd, exp_rd); else passed++;
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic e, rdy; bit ee;
    model_op(1'b1, 2'b00, 32'h100, 32'hDEADBEEF, ee);
    xfer(1'b1, 2'b00, 32'h100, 32'hDEADBEEF, lat, rd, e, rdy);
    total++; if (lat !== 2) $display("FAIL store_latency got %0d exp 2", lat); else passed++;
    total++; if (rdy !== 1'b1) $display("FAIL ready_after_done got %b exp 1", rdy); else passed++;
    total++; if (rd !== exp_rd) $display("FAIL store_keeps_rdata got %h exp %h", rd, exp_rd); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut.mem[16'h100 + i] !== model_mem[32'h100 + i])
        $display("FAIL word_byte%0d got %h exp %h", i, dut.mem[16'h100 + i], model_mem[32'h100 + i]);
      else passed++;
    end
    model_op(1'b0, 2'b00, 32'h100, 32'h0, ee);
    xfer(1'b0, 2'b00, 32'h100, 32'h0, lat, rd, e, rdy);
    total++; if (rd !== exp_rd) $display("FAIL word_load got %h exp %h", rd, exp_rd); else passed++;
  endtask

  task automatic test_sizes();
    int lat; logic [31:0] rd; logic e, rdy; bit ee;
    logic [1:0]  sz_t [5] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
    logic        we_t [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad_t [5] = '{32'h20, 32'h22, 32'h22, 32'h21, 32'h20};
    logic [31:0] wd_t [5] = '{32'h11223344, 32'h0, 32'h0, 32'h99, 32'h0};
    for (int i = 0; i < 5; i++) begin
      model_op(we_t[i], sz_t[i], ad_t[i], wd_t[i], ee);
      xfer(we_t[i], sz_t[i], ad_t[i], wd_t[i], lat, rd, e, rdy);
      total++; if (rd !== exp_rd) $display("FAIL sizes_op%0d got %h exp %h", i, rd, exp_rd); else passed++;
    end
  endtask

  task automatic test_busy_ignored();
    bit ee;
    model_op(1'b0, 2'b00, 32'h100, 32'h0, ee);
    writeEnable = 1'b0; dsize = 2'b00; addr = 32'h100; wData = '0; req = 1'b1;
    @(negedge clk);
    writeEnable = 1'b1; addr = 32'h20; wData = 32'hFFFFFFFF;
    @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL busy_done got %b exp 1", done); else passed++;
    total++; if (rData !== exp_rd) $display("FAIL busy_rdata got %h exp %h", rData, exp_rd); else passed++;
    @(negedge clk);
    req = 1'b0;
    total++; if (ready !== 1'b1 || done !== 1'b0) $display("FAIL busy_return got ready=%b done=%b exp 1/0", ready, done); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut.mem[16'h20 + i] !== model_mem[32'h20 + i])
        $display("FAIL busy_nowrite%0d got %h exp %h", i, dut.mem[16'h20 + i], model_mem[32'h20 + i]);
      else passed++;
    end
  endtask

  task automatic test_reset_abort();
    int lat, seen; logic [31:0] rd; logic e, rdy; bit ee;
    model_op(1'b1, 2'b00, 32'h40, 32'h55667788, ee);
    xfer(1'b1, 2'b00, 32'h40, 32'h55667788, lat, rd, e, rdy);
    writeEnable = 1'b1; dsize = 2'b00; addr = 32'h40; wData = 32'hCAFEF00D; req = 1'b1;
    @(negedge clk);
    req = 1'b0; memRst = 1'b1;
    @(negedge clk);
    seen = (done === 1'b1) ? 1 : 0;
    memRst = 1'b0;
    exp_rd = '0;
    total++; if (ready !== 1'b1) $display("FAIL abort_ready got %b exp 1", ready); else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    total++; if (seen !== 0) $display("FAIL abort_no_done got %0d pulses exp 0", seen); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut.mem[16'h40 + i] !== model_mem[32'h40 + i])
        $display("FAIL abort_byte%0d got %h exp %h", i, dut.mem[16'h40 + i], model_mem[32'h40 + i]);
      else passed++;
    end
    model_op(1'b0, 2'b00, 32'h40, 32'h0, ee);
    xfer(1'b0, 2'b00, 32'h40, 32'h0, lat, rd, e, rdy);
    total++; if (rd !== exp_rd) $display("FAIL abort_readback got %h exp %h", rd, exp_rd); else passed++;
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; logic e, rdy; bit ee;
    int idx [4] = '{SIZE - 2, SIZE - 1, 0, 1};
    model_op(1'b1, 2'b00, 32'(SIZE - 2), 32'h01020304, ee);
    xfer(1'b1, 2'b00, 32'(SIZE - 2), 32'h01020304, lat, rd, e, rdy);
    total++; if (e !== ee) $display("FAIL wrap_err got %b exp %b", e, ee); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut.mem[idx[i]] !== model_mem[idx[i]])
        $display("FAIL wrap_byte%0d got %h exp %h", i, dut.mem[idx[i]], model_mem[idx[i]]);
      else passed++;
    end
    model_op(1'b0, 2'b01, 32'(SIZE - 1), 32'h0, ee);
    xfer(1'b0, 2'b01, 32'(SIZE - 1), 32'h0, lat, rd, e, rdy);
    total++; if (rd !== exp_rd || e !== ee) $display("FAIL wrap_half got %h/%b exp %h/%b", rd, e, exp_rd, ee); else passed++;
    model_op(1'b0, 2'b00, 32'hFFFF0100, 32'h0, ee);
    xfer(1'b0, 2'b00, 32'hFFFF0100, 32'h0, lat, rd, e, rdy);
    total++; if (rd !== exp_rd) $display("FAIL upper_addr got %h exp %h", rd, exp_rd); else passed++;
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, a, wd; logic e, rdy, we; logic [1:0] sz; bit ee;
    int bad_lat = 0, bad_rd = 0, bad_err = 0;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model_op(1'b1, 2'b00, 32'h300 + 32'(4 * i), wd, ee);
      xfer(1'b1, 2'b00, 32'h300 + 32'(4 * i), wd, lat, rd, e, rdy);
    end
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom & 32'hFFFF_C000) | (32'h300 + 32'($urandom_range(0, 60)));
      wd = $urandom;
      model_op(we, sz, a, wd, ee);
      xfer(we, sz, a, wd, lat, rd, e, rdy);
      if (lat != 2) bad_lat++;
      if (rd !== exp_rd) begin
        bad_rd++;
        $display("FAIL rand_rdata op%0d we=%b sz=%0d a=%h got %h exp %h", i, we, sz, a, rd, exp_rd);
      end
      if (e !== ee) bad_err++;
    end
    total++; if (bad_lat !== 0) $display("FAIL rand_latency got %0d bad exp 0", bad_lat); else passed++;
    total++; if (bad_rd !== 0) $display("FAIL rand_rdata_total got %0d bad exp 0", bad_rd); else passed++;
    total++; if (bad_err !== 0) $display("FAIL rand_err got %0d bad exp 0", bad_err); else passed++;
  endtask

  // Continuous req: done when k mod (L+1) == L, ready when k mod (L+1) == 0.
  task automatic test_back_to_back();
    int bad1 = 0, bad2 = 0, bad5 = 0, dones2 = 0;
    bit ee;
    do_reset();
    memRst = 1'b0;
    exp_rd = '0;
    writeEnable = 1'b0; dsize = 2'b00; addr = 32'h300; wData = '0; req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done  !== ((k % 3) == 2) || ready  !== ((k % 3) == 0)) bad2++;
      if (done1 !== ((k % 2) == 1) || ready1 !== ((k % 2) == 0)) bad1++;
      if (done5 !== ((k % 6) == 5) || ready5 !== ((k % 6) == 0)) bad5++;
      if (done === 1'b1) dones2++;
    end
    req = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (bad2 !== 0) $display("FAIL b2b_lat2 got %0d bad cycles exp 0", bad2); else passed++;
    total++; if (bad1 !== 0) $display("FAIL b2b_lat1 got %0d bad cycles exp 0", bad1); else passed++;
    total++; if (bad5 !== 0) $display("FAIL b2b_lat5 got %0d bad cycles exp 0", bad5); else passed++;
    total++; if (dones2 !== 13) $display("FAIL b2b_count got %0d exp 13", dones2); else passed++;
    model_op(1'b0, 2'b00, 32'h300, 32'h0, ee);
    total++; if (rData !== exp_rd) $display("FAIL b2b_rdata got %h exp %h", rData, exp_rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_sizes();
    test_busy_ignored();
    test_reset_abort();
    test_wrap();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got timeout exp finish");
    $fatal(1, "timeout");
  end

endmodule
